// File: rtl/mips_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// Holds state and owner encodings plus default bus widths.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles of an outstanding memory access.
// Flags expiry when the count reaches TIMEOUT; TIMEOUT=0 never expires.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at LIMIT so expiry stays asserted until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access.
// One outstanding access; data side wins ties; one-cycle ready pulses.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    arb_state_t state, state_n;
    owner_t     owner;
    logic       err;
    logic       busy;
    logic       grant;
    logic       expired;

    assign busy  = (state == IF_BUSY) || (state == DM_BUSY);
    assign grant = (state == IDLE) && (dm_req || if_req);

    // Counting starts at the grant edge so expiry lands on the last busy cycle
    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!(grant || busy)),
        .en     (grant || busy),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (dm_req) begin
                    state_n = DM_BUSY;
                end else if (if_req) begin
                    state_n = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ack || expired) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_IF;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else if (state == IDLE) begin
            err <= 1'b0;
            if (dm_req) begin
                owner     <= OWN_DM;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (if_req) begin
                owner     <= OWN_IF;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end else if (busy) begin
            if (mem_ack) begin
                if (owner == OWN_IF) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    dm_rdata <= mem_rdata;
                end
            end else if (expired) begin
                err <= 1'b1;
                if (owner == OWN_IF) begin
                    if_rdata <= '0;
                end else begin
                    dm_rdata <= '0;
                end
            end
        end
    end

    always_comb begin
        mem_req   = busy;
        if_ready  = (state == RESP) && (owner == OWN_IF);
        dm_ready  = (state == RESP) && (owner == OWN_DM);
        bus_err   = (state == RESP) && err;
        stall_if  = if_req && !if_ready;
        stall_mem = dm_req && !dm_ready;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a short timeout.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    int passed;
    int total;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        rst_n = 1'b1;
        tick();

        // Single fetch, ack on third busy cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        #1;
        chk("f_stall_pre", stall_if, 1);
        chk("f_req_pre", mem_req, 0);
        tick();
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h40);
        chk("f_mem_we", mem_we, 0);
        chk("f_stall_b1", stall_if, 1);
        tick();
        chk("f_stall_b2", stall_if, 1);
        chk("f_ready_b2", if_ready, 0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C22_0004;
        tick();
        chk("f_ready", if_ready, 1);
        chk("f_rdata", if_rdata, 32'h8C22_0004);
        chk("f_stall_resp", stall_if, 0);
        chk("f_req_drop", mem_req, 0);
        chk("f_no_err", bus_err, 0);
        if_req  = 1'b0;
        mem_ack = 1'b0;
        tick();
        chk("f_ready_once", if_ready, 0);

        // Simultaneous: data access first, fetch after
        if_req  = 1'b1;
        if_addr = 32'h0000_0044;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0100;
        tick();
        chk("s_addr_dm", mem_addr, 32'h100);
        chk("s_stall_if", stall_if, 1);
        chk("s_stall_mem", stall_mem, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        chk("s_dm_ready", dm_ready, 1);
        chk("s_if_ready0", if_ready, 0);
        chk("s_dm_rdata", dm_rdata, 32'h1111_2222);
        chk("s_if_keep", if_rdata, 32'h8C22_0004);
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        tick();
        chk("s_idle_req", mem_req, 0);
        chk("s_idle_dmrdy", dm_ready, 0);
        tick();
        chk("s_if_req", mem_req, 1);
        chk("s_addr_if", mem_addr, 32'h44);
        chk("s_if_we", mem_we, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        chk("s_if_ready", if_ready, 1);
        chk("s_if_rdata", if_rdata, 32'h3333_4444);
        if_req  = 1'b0;
        mem_ack = 1'b0;
        tick();

        // Store with zero-wait ack
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0200;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_addr", mem_addr, 32'h200);
        chk("st_ready_early", dm_ready, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("st_ready", dm_ready, 1);
        chk("st_rdata_keep", dm_rdata, 32'h1111_2222);
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        mem_ack = 1'b0;
        tick();

        // Timeout with no ack
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0300;
        tick();
        tick();
        tick();
        tick();
        chk("t_busy4_req", mem_req, 1);
        chk("t_busy4_err", bus_err, 0);
        tick();
        chk("t_bus_err", bus_err, 1);
        chk("t_dm_ready", dm_ready, 1);
        chk("t_dm_rdata", dm_rdata, 0);
        chk("t_req_drop", mem_req, 0);
        dm_req = 1'b0;
        tick();
        chk("t_err_once", bus_err, 0);

        // Ack in the expiry cycle wins
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0304;
        tick();
        tick();
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        chk("t2_no_err", bus_err, 0);
        chk("t2_ready", dm_ready, 1);
        chk("t2_rdata", dm_rdata, 32'h5555_AAAA);
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        tick();

        // Reset while data access is busy
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0400;
        tick();
        chk("r_busy", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_req", mem_req, 0);
        chk("r_async_addr", mem_addr, 0);
        chk("r_async_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        tick();
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
        tick();
        chk("r_late_rdy", dm_ready, 0);
        chk("r_late_req", mem_req, 0);
        mem_ack = 1'b0;
        tick();
        chk("r_late_rdy2", dm_ready, 0);
        chk("r_late_rdata", dm_rdata, 0);

        // Fetch address changes while busy
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        tick();
        if_addr = 32'h0000_0084;
        tick();
        chk("i_hold1", mem_addr, 32'h80);
        tick();
        chk("i_hold2", mem_addr, 32'h80);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0001;
        tick();
        chk("i_ready", if_ready, 1);
        chk("i_rdata", if_rdata, 32'h1);
        if_req  = 1'b0;
        mem_ack = 1'b0;
        tick();
        chk("i_idle", if_ready, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
